// File: rtl/custom_pdp_peak_v1_0.sv
// custom_pdp_peak_v1_0
// Power-delay-profile peak tracker for the channel-sounder correlation chain.
// Each input beat is a {Q, I} correlation sample. The block computes |x|^2 per
// sample, tracks the strongest sample of every frame (delimited by tlast), and
// emits one 64-bit result beat per frame: {peak index, shifted/saturated power}.
//
// Optional build macro: PDP_PEAK_THRESH_EN
//   When defined, adds a 'thresh' input and a 'miss_count' output. Frames whose
//   shifted peak power is below 'thresh' produce no result beat. Instead,
//   miss_count increments and saturates at 16'hFFFF.
module custom_pdp_peak_v1_0 #(
    parameter int BRAM_DEPTH_BITS        = 10,
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int POW_SHIFT              = 30
) (
    input  logic                                  aclk,
    input  logic                                  rst,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    input  logic                                  s00_axis_tvalid,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    input  logic                                  m00_axis_tready
`ifdef PDP_PEAK_THRESH_EN
    ,
    input  logic [31:0]                           thresh,
    output logic [15:0]                           miss_count
`endif
);

    localparam logic [BRAM_DEPTH_BITS-1:0] IDX_ONE = 1;

    // Handshake and stall control
    logic stall;
    logic advance;
    logic accept;

    // Sign-extended input components
    logic signed [63:0] i_ext;
    logic signed [63:0] q_ext;
    logic signed [63:0] ii_full;
    logic signed [63:0] qq_full;

    // Input index counter
    logic [BRAM_DEPTH_BITS-1:0] idx_cnt;

    // Stage 1: squared components
    logic                       s1_valid;
    logic [63:0]                s1_ii;
    logic [63:0]                s1_qq;
    logic [BRAM_DEPTH_BITS-1:0] s1_idx;
    logic                       s1_last;

    // Stage 2: power
    logic                       s2_valid;
    logic [63:0]                s2_pow;
    logic [BRAM_DEPTH_BITS-1:0] s2_idx;
    logic                       s2_last;

    // Stage 3: running peak of the current frame
    logic [63:0]                peak_pow;
    logic [BRAM_DEPTH_BITS-1:0] peak_idx;
    logic                       first_of_frame;

    // Stage 3 combinational candidate
    logic                       take_new;
    logic [63:0]                cand_pow;
    logic [BRAM_DEPTH_BITS-1:0] cand_idx;
    logic [63:0]                cand_shifted;
    logic [31:0]                sat_pow;
    logic                       issue;

    // Result register
    logic                              result_valid;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] result_data;

    // tstrb carries no information for this block
    logic unused_tstrb;
    assign unused_tstrb = ^s00_axis_tstrb;

    // A pending result that is not being taken freezes every stage.
    // tready therefore follows m00_axis_tready combinationally.
    assign stall           = result_valid & ~m00_axis_tready;
    assign advance         = ~stall;
    assign s00_axis_tready = ~stall & ~rst;
    assign accept          = s00_axis_tvalid & s00_axis_tready;

    assign i_ext   = {{32{s00_axis_tdata[31]}}, s00_axis_tdata[31:0]};
    assign q_ext   = {{32{s00_axis_tdata[63]}}, s00_axis_tdata[63:32]};
    assign ii_full = i_ext * i_ext;
    assign qq_full = q_ext * q_ext;

    assign m00_axis_tvalid = result_valid;
    assign m00_axis_tdata  = result_data;
    assign m00_axis_tlast  = result_valid;
    assign m00_axis_tstrb  = '1;

    // Stage 1: square I and Q, and tag each beat with its wrapped in-frame index
    always_ff @(posedge aclk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ii    <= '0;
            s1_qq    <= '0;
            s1_idx   <= '0;
            s1_last  <= 1'b0;
            idx_cnt  <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_ii   <= ii_full;
                s1_qq   <= qq_full;
                s1_idx  <= idx_cnt;
                s1_last <= s00_axis_tlast;
                idx_cnt <= s00_axis_tlast ? '0 : idx_cnt + IDX_ONE;
            end
        end
    end

    // Stage 2: sum the squares. The maximum is 2^63, so 64 bits never overflow.
    always_ff @(posedge aclk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_pow   <= '0;
            s2_idx   <= '0;
            s2_last  <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_pow   <= s1_ii + s1_qq;
            s2_idx   <= s1_idx;
            s2_last  <= s1_last;
        end
    end

    // Candidate peak including the current stage-2 beat. A strict compare keeps the earliest index on ties.
    always_comb begin
        take_new     = first_of_frame | (s2_pow > peak_pow);
        cand_pow     = take_new ? s2_pow : peak_pow;
        cand_idx     = take_new ? s2_idx : peak_idx;
        cand_shifted = cand_pow >> POW_SHIFT;
        sat_pow      = (|cand_shifted[63:32]) ? 32'hFFFF_FFFF : cand_shifted[31:0];
        issue        = 1'b1;
`ifdef PDP_PEAK_THRESH_EN
        issue        = (sat_pow >= thresh);
`endif
    end

    // Stage 3: update the running peak, and publish and re-arm at frame end
    always_ff @(posedge aclk) begin
        if (rst) begin
            peak_pow       <= '0;
            peak_idx       <= '0;
            first_of_frame <= 1'b1;
            result_valid   <= 1'b0;
            result_data    <= '0;
        end else begin
            if (result_valid && m00_axis_tready) begin
                result_valid <= 1'b0;
            end
            if (advance && s2_valid) begin
                if (s2_last) begin
                    peak_pow       <= '0;
                    peak_idx       <= '0;
                    first_of_frame <= 1'b1;
                    if (issue) begin
                        result_valid <= 1'b1;
                        result_data  <= C_M00_AXIS_TDATA_WIDTH'({32'(cand_idx), sat_pow});
                    end
                end else begin
                    peak_pow       <= cand_pow;
                    peak_idx       <= cand_idx;
                    first_of_frame <= 1'b0;
                end
            end
        end
    end

`ifdef PDP_PEAK_THRESH_EN
    logic frame_miss;
    assign frame_miss = advance & s2_valid & s2_last & ~issue;

    // Count frames whose peak fell below the threshold, saturating
    always_ff @(posedge aclk) begin
        if (rst) begin
            miss_count <= '0;
        end else if (frame_miss && (miss_count != 16'hFFFF)) begin
            miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule
